// File: rtl/sysx_slave_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : sysx_slave_port_if
//  Purpose  : sysX bus signal bundle between a bus master and a slave port.
//  Signals  : iBusClock     - bus clock, asynchronous to the slave, idles high
//             iBusSelect    - 2-bit chip select
//             iBusMOSI      - master-to-slave byte lane
//             oBusMISO      - slave-to-master byte lane
//             oBusInterrupt - interrupt request from slave to master
//  Revision : 1.0  initial release
// ============================================================================
interface sysx_slave_port_if;
    logic       iBusClock;
    logic [1:0] iBusSelect;
    logic [7:0] iBusMOSI;
    logic [7:0] oBusMISO;
    logic       oBusInterrupt;

    modport master (
        output iBusClock,
        output iBusSelect,
        output iBusMOSI,
        input  oBusMISO,
        input  oBusInterrupt
    );

    modport slave (
        input  iBusClock,
        input  iBusSelect,
        input  iBusMOSI,
        output oBusMISO,
        output oBusInterrupt
    );
endinterface
`default_nettype wire

// File: rtl/sysx_slave_port.sv
`default_nettype none
// ============================================================================
//  Module   : sysx_slave_port
//  Purpose  : sysX bus slave. Oversamples the bus clock with iClock, counts
//             six falling edges per bus word (Load, LoLo, Lo, Hi, HiHi,
//             Store), assembles a 32-bit RX word LSB first into a FIFO and
//             serialises a 32-bit TX word back out on MISO.
//  Ports    : iClock/iReset  - system clock, synchronous active-high reset
//             bus            - sysX bus signals (slave modport)
//             oRxData/oRxValid/iRxReady - RX FIFO head and pop handshake
//             iTxData/iTxValid/oTxReady - TX holding register load handshake
//             iIntRequest    - local interrupt source, ORed into bus interrupt
//             oOverflow/iOverflowClear  - sticky RX overflow flag and clear
//  Revision : 1.0  initial release
// ============================================================================
module sysx_slave_port #(
    parameter logic [1:0] ADDRESS      = 2'h0,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  wire logic        iClock,
    input  wire logic        iReset,
    sysx_slave_port_if.slave bus,
    output logic [31:0]      oRxData,
    output logic             oRxValid,
    input  wire logic        iRxReady,
    input  wire logic [31:0] iTxData,
    input  wire logic        iTxValid,
    output logic             oTxReady,
    input  wire logic        iIntRequest,
    output logic             oOverflow,
    input  wire logic        iOverflowClear
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
    localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {
        PH_LOAD  = 3'd0,
        PH_LOLO  = 3'd1,
        PH_LO    = 3'd2,
        PH_HI    = 3'd3,
        PH_HIHI  = 3'd4,
        PH_STORE = 3'd5
    } phase_e;

    // State registers
    logic [1:0]        sync_q;
    logic              hist_q;
    phase_e            phase_q,     phase_d;
    logic [31:0]       word_q,      word_d;
    logic [31:0]       shadow_q,    shadow_d;
    logic [31:0]       hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    logic [IDLE_W-1:0] idle_q,      idle_d;
    logic [7:0]        miso_q,      miso_d;
    logic [AW:0]       wr_ptr_q,    wr_ptr_d;
    logic [AW:0]       rd_ptr_q,    rd_ptr_d;
    logic              ovf_q,       ovf_d;
    logic              irq_q,       irq_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic selected, fall, timeout, push_req, push_ok, pop, empty, full;

    always_comb begin
        phase_d     = phase_q;
        word_d      = word_q;
        shadow_d    = shadow_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idle_d      = idle_q;
        push_req    = 1'b0;

        selected = (bus.iBusSelect == ADDRESS);
        fall     = hist_q & ~sync_q[1];
        // Timeout fires on the IDLE_TIMEOUT-th consecutive high cycle.
        timeout  = sync_q[1] && (idle_q == IDLE_MAX);

        if (!sync_q[1]) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_ONE;
        end

        // Holding register only accepts when empty, so the shadow load below
        // (which only fires when it is full) can never collide with a write.
        if (iTxValid && !hold_full_q) begin
            hold_d      = iTxData;
            hold_full_d = 1'b1;
        end

        if (!selected || timeout) begin
            phase_d = PH_LOAD;
        end else if (fall) begin
            case (phase_q)
                PH_LOAD: begin
                    if (hold_full_q) begin
                        shadow_d    = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shadow_d = 32'hFFFF_FFFF;
                    end
                    phase_d = PH_LOLO;
                end
                PH_LOLO: begin word_d[7:0]   = bus.iBusMOSI; phase_d = PH_LO;    end
                PH_LO:   begin word_d[15:8]  = bus.iBusMOSI; phase_d = PH_HI;    end
                PH_HI:   begin word_d[23:16] = bus.iBusMOSI; phase_d = PH_HIHI;  end
                PH_HIHI: begin word_d[31:24] = bus.iBusMOSI; phase_d = PH_STORE; end
                PH_STORE: begin
                    push_req = 1'b1;
                    phase_d  = PH_LOAD;
                end
                default: phase_d = PH_LOAD;
            endcase
        end

        case (phase_q)
            PH_LOLO: miso_d = shadow_q[7:0];
            PH_LO:   miso_d = shadow_q[15:8];
            PH_HI:   miso_d = shadow_q[23:16];
            PH_HIHI: miso_d = shadow_q[31:24];
            default: miso_d = 8'hFF;
        endcase

        // RX FIFO: a push into a full FIFO still succeeds when the head is
        // popped in the same cycle.
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && iRxReady;
        push_ok = push_req && (!full || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        // A same-cycle overflow beats the clear.
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end else if (iOverflowClear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        irq_d = !empty || iIntRequest;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            // Synchronizer resets high so no false falling edge follows reset.
            sync_q      <= 2'b11;
            hist_q      <= 1'b1;
            phase_q     <= PH_LOAD;
            word_q      <= '0;
            shadow_q    <= 32'hFFFF_FFFF;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idle_q      <= '0;
            miso_q      <= 8'hFF;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.iBusClock};
            hist_q      <= sync_q[1];
            phase_q     <= phase_d;
            word_q      <= word_d;
            shadow_q    <= shadow_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idle_q      <= idle_d;
            miso_q      <= miso_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge iClock) begin
        if (!iReset && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= word_q;
        end
    end

    assign oRxData           = mem_q[rd_ptr_q[AW-1:0]];
    assign oRxValid          = !empty;
    assign oTxReady          = !hold_full_q;
    assign oOverflow         = ovf_q;
    assign bus.oBusMISO      = miso_q;
    assign bus.oBusInterrupt = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_sysx_slave_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysx_slave_port
//  Purpose  : Self-checking bench for sysx_slave_port. Drives a slow sysX
//             master (16 system clocks per bus clock), keeps a reference
//             model of phase, TX holding/shadow and RX contents, and compares
//             popped RX words against a queue of expected words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sysx_slave_port;
    logic        iClock = 1'b0;
    logic        iReset;
    logic [31:0] oRxData;
    logic        oRxValid;
    logic        iRxReady;
    logic [31:0] iTxData;
    logic        iTxValid;
    logic        oTxReady;
    logic        iIntRequest;
    logic        oOverflow;
    logic        iOverflowClear;

    sysx_slave_port_if bus ();

    sysx_slave_port #(
        .ADDRESS      (2'h0),
        .FIFO_DEPTH   (4),
        .IDLE_TIMEOUT (64)
    ) dut (
        .iClock         (iClock),
        .iReset         (iReset),
        .bus            (bus),
        .oRxData        (oRxData),
        .oRxValid       (oRxValid),
        .iRxReady       (iRxReady),
        .iTxData        (iTxData),
        .iTxValid       (iTxValid),
        .oTxReady       (oTxReady),
        .iIntRequest    (iIntRequest),
        .oOverflow      (oOverflow),
        .iOverflowClear (iOverflowClear)
    );

    always #5 iClock = ~iClock;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [31:0] exp_q[$];
    int          m_phase;
    logic [31:0] m_shadow;
    logic [31:0] m_hold;
    logic        m_hold_full;
    logic [31:0] m_word;
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_shadow    = 32'hFFFF_FFFF;
        m_hold      = '0;
        m_hold_full = 1'b0;
        m_word      = '0;
        m_ovf       = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge iClock);
        iReset = 1'b1;
        repeat (3) @(negedge iClock);
        iReset = 1'b0;
        model_reset();
        @(negedge iClock);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_rxvalid"}, 32'(oRxValid), 32'd0);
        check({pfx, "_txready"}, 32'(oTxReady), 32'd1);
        check({pfx, "_miso"},    32'(bus.oBusMISO), 32'hFF);
        check({pfx, "_ovf"},     32'(oOverflow), 32'd0);
        check({pfx, "_irq"},     32'(bus.oBusInterrupt), 32'd0);
    endtask

    task automatic load_tx(input logic [31:0] d);
        @(negedge iClock);
        iTxData  = d;
        iTxValid = 1'b1;
        @(negedge iClock);
        iTxValid = 1'b0;
        m_hold      = d;
        m_hold_full = 1'b1;
        check("txready_drop", 32'(oTxReady), 32'd0);
    endtask

    // One bus clock period: low 8 system clocks, high 8 system clocks.
    task automatic bus_edge(input logic [7:0] mosi, input logic chk_miso);
        logic [7:0] exp_miso;
        bus.iBusMOSI  = mosi;
        bus.iBusClock = 1'b0;
        repeat (8) @(negedge iClock);
        bus.iBusClock = 1'b1;
        repeat (8) @(negedge iClock);
        if (bus.iBusSelect == 2'h0) begin
            case (m_phase)
                0: begin
                    m_shadow    = m_hold_full ? m_hold : 32'hFFFF_FFFF;
                    m_hold_full = 1'b0;
                end
                5: begin
                    if (exp_q.size() < 4) exp_q.push_back(m_word);
                    else                  m_ovf = 1'b1;
                end
                default: m_word[8*(m_phase-1) +: 8] = mosi;
            endcase
            m_phase = (m_phase == 5) ? 0 : m_phase + 1;
        end else begin
            m_phase = 0;
        end
        if (chk_miso) begin
            exp_miso = (m_phase >= 1 && m_phase <= 4) ? m_shadow[8*(m_phase-1) +: 8] : 8'hFF;
            check("miso", 32'(bus.oBusMISO), 32'(exp_miso));
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        for (int i = 0; i < 6; i++) begin
            bus_edge((i >= 1 && i <= 4) ? d[8*(i-1) +: 8] : 8'h00, 1'b1);
            if (i == 0) check("txready_back", 32'(oTxReady), 32'(!m_hold_full));
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) bus_edge(8'h5A + 8'(i), 1'b0);
    endtask

    // Pop everything the model expects and confirm the FIFO is then empty.
    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            @(negedge iClock);
            check({tag, "_valid"}, 32'(oRxValid), 32'd1);
            check({tag, "_data"}, oRxData, e);
            iRxReady = 1'b1;
            @(negedge iClock);
            iRxReady = 1'b0;
        end
        @(negedge iClock);
        check({tag, "_empty"}, 32'(oRxValid), 32'd0);
    endtask

    initial begin
        iReset         = 1'b1;
        iRxReady       = 1'b0;
        iTxData        = '0;
        iTxValid       = 1'b0;
        iIntRequest    = 1'b0;
        iOverflowClear = 1'b0;
        bus.iBusClock  = 1'b1;
        bus.iBusSelect = 2'h0;
        bus.iBusMOSI   = 8'h00;
        model_reset();

        do_reset();
        check_reset_state("rst");

        // Word with TX data loaded beforehand
        load_tx(32'hCAFE_F00D);
        send_word(32'h1122_3344);
        repeat (2) @(negedge iClock);
        check("irq_rx", 32'(bus.oBusInterrupt), 32'd1);
        drain("w1");
        repeat (2) @(negedge iClock);
        check("irq_idle", 32'(bus.oBusInterrupt), 32'd0);

        // No TX data: MISO stays FF, word still received
        send_word(32'h8765_4321);
        drain("w2");

        // Local interrupt source
        @(negedge iClock);
        iIntRequest = 1'b1;
        @(negedge iClock);
        check("irq_local", 32'(bus.oBusInterrupt), 32'd1);
        iIntRequest = 1'b0;
        @(negedge iClock);
        check("irq_local_off", 32'(bus.oBusInterrupt), 32'd0);

        // Overflow: five words into a depth-4 FIFO
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i));
        check("ovf_set", 32'(oOverflow), 32'(m_ovf));
        @(negedge iClock);
        iOverflowClear = 1'b1;
        @(negedge iClock);
        iOverflowClear = 1'b0;
        check("ovf_clear", 32'(oOverflow), 32'd0);
        drain("ovf");

        // Idle timeout discards a partial word
        send_partial(3);
        repeat (80) @(negedge iClock);
        m_phase = 0;
        send_word(32'hA5A5_A5A5);
        drain("tmo");

        // Deselect mid-word; edges while deselected are ignored
        send_partial(2);
        bus.iBusSelect = 2'h1;
        send_partial(3);
        bus.iBusSelect = 2'h0;
        @(negedge iClock);
        send_word(32'hDEAD_BEEF);
        drain("sel");

        // Reset mid-word discards partial word and pending holding data
        load_tx(32'h0BAD_F00D);
        send_partial(3);
        load_tx(32'h1234_5678);
        do_reset();
        check_reset_state("mid");
        send_word(32'h0F1E_2D3C);
        drain("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/sysx_slave_port.md
SYSX_SLAVE_PORT -- requirements
Module: sysx_slave_port

Interface
REQ-001 SHALL provide parameter ADDRESS, default 2'h0: bus select value this port answers to.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL provide parameter IDLE_TIMEOUT, default 64: iClock cycles of continuous high bus clock that abort a partial word.
REQ-004 SHALL have ports: iClock in 1, system clock.
REQ-005 iReset in 1, synchronous active-high reset.
REQ-006 iBusClock in 1, sysX bus clock, asynchronous, idles high.
REQ-007 iBusSelect in 2, sysX chip select.
REQ-008 iBusMOSI in 8, master-to-slave byte lane.
REQ-009 oBusMISO out 8, slave-to-master byte lane.
REQ-010 oBusInterrupt out 1, interrupt request to master.
REQ-011 oRxData out 32, FIFO head word; oRxValid out 1; iRxReady in 1: pop handshake.
REQ-012 iTxData in 32; iTxValid in 1; oTxReady out 1: transmit-word load handshake.
REQ-013 iIntRequest in 1, local interrupt source; oOverflow out 1, sticky; iOverflowClear in 1.

Function
REQ-014 One clock (iClock), synchronous active-high reset (iReset); all state updates on posedge iClock.
REQ-015 iBusClock SHALL pass a 2-flop synchronizer plus one history flop; a falling edge is synced-prev=1 and synced=0.
REQ-016 Operation requires iClock >= 8x bus clock frequency; faster bus clocks are out of scope.
REQ-017 Phase counter P (0..5) SHALL advance by 1 on each detected falling edge while iBusSelect==ADDRESS, wrapping 5->0.
REQ-018 Bus word = 6 falling edges, mapped to master states Load, LoLo, Lo, Hi, HiHi, Store.
REQ-019 On the falling edge with P==1,2,3,4, iBusMOSI SHALL be captured into word bits [7:0],[15:8],[23:16],[31:24] respectively (LSB first).
REQ-020 On the falling edge with P==5, the assembled word SHALL be pushed into the RX FIFO.
REQ-021 On the falling edge with P==0, the TX shadow SHALL load from the TX holding register if full (holding becomes empty), else 32'hFFFFFFFF.
REQ-022 oBusMISO SHALL be registered: shadow byte (P-1) when P in 1..4 (byte 0 first), else 8'hFF.
REQ-023 oTxReady SHALL be 1 when holding register empty; iTxValid&&oTxReady loads iTxData, oTxReady drops next cycle.
REQ-024 Shadow load and new holding write SHALL NOT collide: holding accepts only when empty.
REQ-025 iBusSelect!=ADDRESS SHALL force P=0 and discard the partial word; edges are ignored while deselected.
REQ-026 Synced bus clock high for IDLE_TIMEOUT consecutive cycles SHALL force P=0 and discard the partial word.
REQ-027 RX FIFO: oRxValid=!empty; oRxData=head word; pop when oRxValid&&iRxReady.
REQ-028 Push when full with no same-cycle pop SHALL drop the word and set oOverflow; push when full with same-cycle pop SHALL succeed.
REQ-029 oOverflow SHALL clear on iOverflowClear; a same-cycle overflow event wins (stays 1).
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-031 oBusInterrupt SHALL be registered: (FIFO non-empty) OR iIntRequest, one-cycle latency.

Reset
REQ-032 On iReset: P=0, FIFO empty, oRxValid=0, holding empty, oTxReady=1, shadow=32'hFFFFFFFF, oBusMISO=8'hFF, oOverflow=0, oBusInterrupt=0.
REQ-033 Synchronizer and history flops SHALL reset to 1 so no false falling edge is seen after reset.
REQ-034 Reset mid-word SHALL discard the partial word and any pending holding data.

Verification
REQ-035 Select=ADDRESS, 6 bus edges, MOSI bytes 44,33,22,11 on P1..P4 -> oRxValid=1, oRxData=32'h11223344.
REQ-036 Holding loaded with 32'hCAFEF00D before word -> oBusMISO 0D,F0,FE,CA during P1..P4, oTxReady back to 1 after P0 edge.
REQ-037 No TX data loaded -> oBusMISO=8'hFF in all phases; received word still pushed.
REQ-038 Five words with iRxReady=0, depth 4 -> 4 entries retained, oOverflow=1; iOverflowClear -> 0.
REQ-039 Three edges then bus clock high 64 cycles, then full word 32'hA5A5A5A5 -> only 32'hA5A5A5A5 in FIFO.
REQ-040 Select changed mid-word, then reselected full word -> partial discarded, one word; iReset mid-word -> all outputs per REQ-032.
